register_file32: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the 32-bit RISC datapath.
- One synchronous write port and two independent asynchronous read ports.
- Read port A drives out1 and read port B drives out0; these feed the ALU operand buses.

---
 rtl/register_file32_if.sv | 18 +
 rtl/register_file32.sv | 56 +++++
 tb/tb_register_file32.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/register_file32_if.sv
// Register file port bundle: write port plus two read ports.
// The master side (datapath / bench) drives the write data and selects and
// receives both read buses. The slave side is the register file itself.
interface register_file32_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] in;
    logic              wen;
    logic [ADDR_W-1:0] wsel;
    logic [ADDR_W-1:0] asel;
    logic [ADDR_W-1:0] bsel;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] out0;

    modport master (output in, wen, wsel, asel, bsel, input out1, out0);
    modport slave  (input in, wen, wsel, asel, bsel, output out1, out0);
endinterface

// File: rtl/register_file32.sv
// 32 x 32-bit register file: one synchronous write port and two
// combinational read ports (A -> out1, B -> out0), with no write-to-read
// bypass. The registers clear asynchronously when reset is low.
// Optional macro REGFILE_ZERO_REG_EN: R0 is hardwired to zero. It has no
// storage, writes to it are dropped, and reads of it return 0.
module register_file32 #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input logic               clk,
    input logic               reset,
    register_file32_if.slave  rf
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             wdec;

    // One-hot write decode gated by wen. An X select never sets a decode
    // bit, so no register can be disturbed by it.
    always_comb begin
        wdec = '0;
        if (rf.wen) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rf.wsel == ADDR_W'(i)) wdec[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
`ifdef REGFILE_ZERO_REG_EN
        if (g == 0) begin : g_zero
            // R0 is a constant. Its decode bit is intentionally left unused.
            assign regs[g] = '0;
        end else begin : g_flop
            // Storage register with async clear; reset overrides any write.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)       regs[g] <= '0;
                else if (wdec[g]) regs[g] <= rf.in;
            end
        end
`else
        // Storage register with async clear; reset overrides any write.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)       regs[g] <= '0;
            else if (wdec[g]) regs[g] <= rf.in;
        end
`endif
    end

    // Each read port is a plain mux over the array. A read sees the old
    // value until the write edge.
    assign rf.out1 = regs[rf.asel];
    assign rf.out0 = regs[rf.bsel];

endmodule

// File: tb/tb_register_file32.sv
// Bench for register_file32. The stimulus process drives the ports and keeps
// an array model of the register contents. It pushes the expected read pair
// into a queue and raises a sample strobe. A separate monitor pops each
// entry and compares it with the live outputs.
module tb_register_file32;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk;
    logic reset;

    register_file32_if #(.DATA_W(DW), .ADDR_W(AW)) rf ();

    register_file32 #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] e1;
        logic [31:0] e0;
    } exp_t;

    exp_t        sq[$];
    event        smp_ev;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [32];

    // Monitor: on each sample strobe, pop and compare every pending entry.
    initial begin
        forever begin
            @(smp_ev);
            while (sq.size() > 0) begin
                exp_t e;
                e = sq.pop_front();
                n_cmp++;
                if (rf.out1 !== e.e1 || rf.out0 !== e.e0) begin
                    n_bad++;
                    $display("FAIL %s: out1=%h out0=%h, expected out1=%h out0=%h",
                             e.nm, rf.out1, rf.out0, e.e1, e.e0);
                end
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Expected read data: R0 is zero when the optional feature is on.
    function automatic logic [31:0] rd(input logic [4:0] a);
        return (ZR && a == 5'd0) ? 32'h0 : model[a];
    endfunction

    task automatic check(input string nm);
        exp_t e;
        #1;
        e.nm = nm;
        e.e1 = rd(rf.asel);
        e.e0 = rd(rf.bsel);
        sq.push_back(e);
        ->smp_ev;
        #1;
    endtask

    // One clock: the model commits the write only if it is enabled and reset
    // is high at the edge.
    task automatic tick();
        @(posedge clk);
        if (reset === 1'b1 && rf.wen === 1'b1) begin
            if (!(ZR && rf.wsel == 5'd0)) model[rf.wsel] = rf.in;
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] ws, input logic [31:0] d);
        rf.wen  = 1'b1;
        rf.wsel = ws;
        rf.in   = d;
        tick();
        rf.wen  = 1'b0;
    endtask

    task automatic sel(input logic [4:0] a, input logic [4:0] b);
        rf.asel = a;
        rf.bsel = b;
    endtask

    initial begin
        reset   = 1'b0;
        rf.wen  = 1'b0;
        rf.wsel = '0;
        rf.in   = '0;
        rf.asel = 5'd3;
        rf.bsel = 5'd31;
        clear_model();

        // Reset is held for two cycles, then released at a falling edge.
        @(negedge clk);
        check("in_reset");
        @(negedge clk);
        reset = 1'b1;
        check("reset_read");

        // Four writes on consecutive edges, then a dual-port read.
        rf.wen = 1'b1;
        rf.wsel = 5'd8; rf.in = 32'h00008888; tick();
        rf.wsel = 5'd3; rf.in = 32'h00003333; tick();
        rf.wsel = 5'd7; rf.in = 32'h00007777; tick();
        rf.wsel = 5'd6; rf.in = 32'h00006666; tick();
        rf.wen = 1'b0;
        sel(5'd3, 5'd8); check("dual_read_3_8");
        sel(5'd7, 5'd6); check("dual_read_7_6");

        // The same register on both ports, including the top address.
        wr(5'd2, 32'h00002222);
        wr(5'd9, 32'h00009999);
        sel(5'd9, 5'd9);   check("same_reg_9");
        sel(5'd2, 5'd2);   check("same_reg_2");
        wr(5'd27, 32'h00002727);
        wr(5'd31, 32'h0000FFFF);
        sel(5'd27, 5'd27); check("same_reg_27");
        sel(5'd31, 5'd31); check("same_reg_31");

        // An overwrite replaces the whole value; neighbours are unaffected.
        wr(5'd9, 32'h00005A5A);
        sel(5'd9, 5'd9);   check("overwrite_9");
        sel(5'd8, 5'd7);   check("untouched_8_7");

        // With wen low, nothing is written.
        rf.wen = 1'b0; rf.in = 32'hDEADBEEF; rf.wsel = 5'd3;
        repeat (3) tick();
        sel(5'd3, 5'd3);   check("wen_gated_3");

        // Read during write: the old value shows before the edge, the new one after.
        rf.wen = 1'b1; rf.wsel = 5'd7; rf.in = 32'h12345678;
        sel(5'd7, 5'd6);
        check("rdw_before");
        tick();
        rf.wen = 1'b0;
        check("rdw_after");

        // Write to R0. The model decides whether it sticks (feature off) or not (on).
        wr(5'd0, 32'hFFFFFFFF);
        sel(5'd0, 5'd0);   check("r0_write");

        // Random traffic; each cycle is read before its edge.
        for (int i = 0; i < 300; i++) begin
            rf.wen  = 1'($urandom_range(0, 1));
            rf.wsel = 5'($urandom);
            rf.in   = $urandom;
            rf.asel = ($urandom_range(0, 3) == 0) ? rf.wsel : 5'($urandom);
            rf.bsel = 5'($urandom);
            check("random");
            tick();
        end
        rf.wen = 1'b0;
        sel(5'd0, 5'd31); check("random_post");

        // Async reset between edges with a write pending: the outputs clear at once.
        rf.wen = 1'b1; rf.wsel = 5'd5; rf.in = 32'hCAFEF00D;
        sel(5'd7, 5'd9);
        #2;
        reset = 1'b0;
        clear_model();
        check("async_reset");
        tick();                      // reset must override the pending write
        sel(5'd5, 5'd9); check("reset_over_write");
        rf.wen = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel(5'(i), 5'(31 - i));
            check("cleared_sweep");
        end

        #5;
        if (sq.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d entries left, expected 0", sq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
